tdp_bram_gen: RTL
=================

TDP_BRAM_GEN -- requirements
Module: tdp_bram_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- G_ADDR, 6, address width; depth = 2**G_ADDR.
- G_WIDTH, 16, data width; SHALL be a multiple of G_BYTE.
- G_BYTE, 8, byte-lane width; NB = G_WIDTH/G_BYTE lanes.
- G_MODE, 0, write-port read behaviour: 0 NO_CHANGE, 1 READ_FIRST, 2 WRITE_FIRST.
- G_LAT, 1, read latency in cycles; legal values 1 or 2.
- G_INIT_CLR, 1, 1 = zero-fill the memory after reset.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock for both ports.
- rst_n, in, 1, asynchronous active-low reset.
- ena / enb, in, 1, port enable.
- wea / web, in, NB, per-lane write enable.
- addra / addrb, in, G_ADDR, address.
- dia / dib, in, G_WIDTH, write data.
- doa / dob, out, G_WIDTH, read data.
- vala / valb, out, 1, read data valid.
- init_done, out, 1, memory ready.
- coll, out, 1, collision pulse.
- coll_cnt, out, 8, saturating collision count.

Function
REQ-003 The FSM SHALL have two states, CLEAR and READY, and SHALL enter CLEAR on reset when G_INIT_CLR=1, otherwise READY.
REQ-004 In CLEAR the block SHALL write zero to address 0, 1, ..., DEPTH-1, one address per cycle, and SHALL move to READY after the last write, for DEPTH cycles total.
REQ-005 init_done SHALL be 0 in CLEAR and 1 in READY; it SHALL rise in the cycle after the write to DEPTH-1.
REQ-006 In CLEAR, port inputs SHALL be ignored: no writes, vala/valb = 0, coll = 0.
REQ-007 In READY, an enabled write SHALL update only the lanes whose we bit is 1; all other lanes SHALL keep their contents.
REQ-008 A port with en=1 SHALL assert its val exactly G_LAT cycles later, together with its data; when G_LAT=2 the second stage SHALL be a pure output register.
REQ-009 Read behaviour when the same port is writing (any we bit set):
- NO_CHANGE: no val pulse, and do SHALL hold its last value.
- READ_FIRST: do SHALL return the pre-write contents, and val SHALL pulse.
- WRITE_FIRST: do SHALL return the merged post-write word, and val SHALL pulse.
REQ-010 A port with en=0 SHALL not pulse val, and its do SHALL hold its last value.
REQ-011 A collision SHALL be: ena=enb=1, addra=addrb, and at least one port writing.
REQ-012 coll SHALL pulse high 1 cycle after a collision.
REQ-013 coll_cnt SHALL increment on each collision and SHALL saturate at 255.
REQ-014 Write-write collisions:
- Lanes written by both ports SHALL take port A data.
- Lanes written by only one port SHALL take that port's data.
REQ-015 Read-write collisions: a non-writing port reading the other port's write address SHALL return the pre-write contents.
REQ-016 Reads SHALL be deterministic in every case; no X values on any output in READY.

Reset
REQ-017 On rst_n=0, the following SHALL clear immediately: doa, dob, vala, valb, coll, coll_cnt, init_done, the pipeline registers and the clear-address counter.
REQ-018 Reset SHALL not clear the memory array itself; zero-fill happens only through CLEAR.
REQ-019 Reset asserted during CLEAR SHALL restart the fill from address 0 after release.
REQ-020 The first CLEAR write SHALL occur on the first clk edge after rst_n deasserts.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset release with G_ADDR=6, G_INIT_CLR=1 -> init_done rises 64 cycles later; a read of every address returns 0x0000.
- READY, G_LAT=1: A writes 0xBEEF to addr 5 with wea=2'b11, then B reads addr 5 -> valb=1 with dob=0xBEEF one cycle after the read.
- Addr 5 = 0xBEEF; A writes 0x1234 with wea=2'b01 -> addr 5 becomes 0xBE34. A's read on that write cycle:
  - G_MODE=1: doa=0xBEEF, vala=1.
  - G_MODE=2: doa=0xBE34, vala=1.
  - G_MODE=0: doa unchanged, vala=0.
- Both ports write addr 9 (A 0xAAAA, B 0x5555, both lanes) -> memory holds 0xAAAA, coll pulses once, coll_cnt 0->1; 300 further collisions -> coll_cnt=255.
- G_LAT=2: B reads addr 5 in back-to-back cycles -> valb high for 2 consecutive cycles starting 2 cycles after the first read, data in order.
- rst_n pulsed low at clear address 30 -> all outputs 0 immediately; after release the fill restarts at 0 and init_done rises 64 cycles later.

Source files
------------

// File: rtl/tdp_bram_gen.sv
`timescale 1ns/1ps
// True dual-port block RAM with per-lane write enables, selectable write-port read mode,
// 1- or 2-cycle read latency, optional zero-fill after reset and collision monitoring.
module tdp_bram_gen #(
    parameter int G_ADDR     = 6,
    parameter int G_WIDTH    = 16,
    parameter int G_BYTE     = 8,
    parameter int G_MODE     = 0,
    parameter int G_LAT      = 1,
    parameter int G_INIT_CLR = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic                        enb,
    input  logic [G_WIDTH/G_BYTE-1:0]   wea,
    input  logic [G_WIDTH/G_BYTE-1:0]   web,
    input  logic [G_ADDR-1:0]           addra,
    input  logic [G_ADDR-1:0]           addrb,
    input  logic [G_WIDTH-1:0]          dia,
    input  logic [G_WIDTH-1:0]          dib,
    output logic [G_WIDTH-1:0]          doa,
    output logic [G_WIDTH-1:0]          dob,
    output logic                        vala,
    output logic                        valb,
    output logic                        init_done,
    output logic                        coll,
    output logic [7:0]                  coll_cnt
);
    localparam int NB    = G_WIDTH / G_BYTE;
    localparam int DEPTH = 2 ** G_ADDR;

    typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

    state_t               r_state, w_state_nxt;
    logic [G_ADDR-1:0]    r_clr_addr;
    logic [G_WIDTH-1:0]   r_mem [DEPTH];
    logic                 r_init_done, r_coll;
    logic [7:0]           r_coll_cnt;
    logic [G_WIDTH-1:0]   r_da1, r_db1;
    logic                 r_va1, r_vb1;

    logic                 w_ready, w_wr_a, w_wr_b, w_same, w_coll;
    logic [G_WIDTH-1:0]   w_old_a, w_old_b, w_post_a, w_post_b, w_rd_a, w_rd_b;
    logic                 w_rv_a, w_rv_b;

    assign w_ready = (r_state == S_READY);
    assign w_same  = (addra == addrb);
    assign w_wr_a  = w_ready & ena & (|wea);
    assign w_wr_b  = w_ready & enb & (|web);
    assign w_coll  = w_ready & ena & enb & w_same & (w_wr_a | w_wr_b);
    assign w_old_a = r_mem[addra];
    assign w_old_b = r_mem[addrb];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= (G_INIT_CLR == 1) ? S_CLEAR : S_READY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: leave CLEAR once the last address has been zeroed
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: begin
                if (r_clr_addr == G_ADDR'(DEPTH - 1)) w_state_nxt = S_READY;
                else                                 w_state_nxt = S_CLEAR;
            end
            S_READY: w_state_nxt = S_READY;
            default: w_state_nxt = S_READY;
        endcase
    end

    // Clear-address counter, init flag and collision monitor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_addr  <= '0;
            r_init_done <= 1'b0;
            r_coll      <= 1'b0;
            r_coll_cnt  <= 8'd0;
        end else begin
            r_clr_addr  <= (r_state == S_CLEAR) ? r_clr_addr + G_ADDR'(1) : r_clr_addr;
            r_init_done <= (w_state_nxt == S_READY);
            r_coll      <= w_coll;
            r_coll_cnt  <= (w_coll && (r_coll_cnt != 8'hFF)) ? r_coll_cnt + 8'd1 : r_coll_cnt;
        end
    end

    // Post-write word seen at each port's address; port A owns lanes both ports write
    always_comb begin
        w_post_a = w_old_a;
        w_post_b = w_old_b;
        for (int l = 0; l < NB; l++) begin
            if (ena && wea[l])                w_post_a[l*G_BYTE +: G_BYTE] = dia[l*G_BYTE +: G_BYTE];
            else if (enb && web[l] && w_same) w_post_a[l*G_BYTE +: G_BYTE] = dib[l*G_BYTE +: G_BYTE];
            else                              w_post_a[l*G_BYTE +: G_BYTE] = w_old_a[l*G_BYTE +: G_BYTE];
            if (ena && wea[l] && w_same)      w_post_b[l*G_BYTE +: G_BYTE] = dia[l*G_BYTE +: G_BYTE];
            else if (enb && web[l])           w_post_b[l*G_BYTE +: G_BYTE] = dib[l*G_BYTE +: G_BYTE];
            else                              w_post_b[l*G_BYTE +: G_BYTE] = w_old_b[l*G_BYTE +: G_BYTE];
        end
    end

    // Read-data selection according to write-port mode
    always_comb begin
        w_rv_a = 1'b0;
        w_rd_a = w_old_a;
        w_rv_b = 1'b0;
        w_rd_b = w_old_b;
        if (w_ready && ena && !w_wr_a) begin
            w_rv_a = 1'b1;
        end else if (w_wr_a) begin
            case (G_MODE)
                32'sd1:  w_rv_a = 1'b1;
                32'sd2:  begin w_rv_a = 1'b1; w_rd_a = w_post_a; end
                default: w_rv_a = 1'b0;
            endcase
        end else begin
            w_rv_a = 1'b0;
        end
        if (w_ready && enb && !w_wr_b) begin
            w_rv_b = 1'b1;
        end else if (w_wr_b) begin
            case (G_MODE)
                32'sd1:  w_rv_b = 1'b1;
                32'sd2:  begin w_rv_b = 1'b1; w_rd_b = w_post_b; end
                default: w_rv_b = 1'b0;
            endcase
        end else begin
            w_rv_b = 1'b0;
        end
    end

    // Memory array: zero-fill in CLEAR, lane-masked writes in READY; never reset
    always_ff @(posedge clk) begin
        if (rst_n && (r_state == S_CLEAR)) begin
            r_mem[r_clr_addr] <= '0;
        end else if (rst_n && (r_state == S_READY)) begin
            for (int l = 0; l < NB; l++) begin
                if (ena && wea[l])
                    r_mem[addra][l*G_BYTE +: G_BYTE] <= dia[l*G_BYTE +: G_BYTE];
                if (enb && web[l] && !(ena && wea[l] && w_same))
                    r_mem[addrb][l*G_BYTE +: G_BYTE] <= dib[l*G_BYTE +: G_BYTE];
            end
        end
    end

    // First read stage; data holds whenever no valid read is produced
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_va1 <= 1'b0;
            r_da1 <= '0;
            r_vb1 <= 1'b0;
            r_db1 <= '0;
        end else begin
            r_va1 <= w_rv_a;
            r_da1 <= w_rv_a ? w_rd_a : r_da1;
            r_vb1 <= w_rv_b;
            r_db1 <= w_rv_b ? w_rd_b : r_db1;
        end
    end

    generate
        if (G_LAT == 2) begin : g_lat2
            logic [G_WIDTH-1:0] r_da2, r_db2;
            logic               r_va2, r_vb2;
            // Pure output register stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_va2 <= 1'b0;
                    r_da2 <= '0;
                    r_vb2 <= 1'b0;
                    r_db2 <= '0;
                end else begin
                    r_va2 <= r_va1;
                    r_da2 <= r_da1;
                    r_vb2 <= r_vb1;
                    r_db2 <= r_db1;
                end
            end
            assign doa  = r_da2;
            assign vala = r_va2;
            assign dob  = r_db2;
            assign valb = r_vb2;
        end else begin : g_lat1
            assign doa  = r_da1;
            assign vala = r_va1;
            assign dob  = r_db1;
            assign valb = r_vb1;
        end
    endgenerate

    assign init_done = r_init_done;
    assign coll      = r_coll;
    assign coll_cnt  = r_coll_cnt;
endmodule
